// File: rtl/img_uart_sender.sv
// Frame-buffer to 8N1 UART streamer: walks BRAM addresses 0..NUM_PIXELS-1, each pixel sent LSB byte first.
// Defining IMG_CHECKSUM_EN appends an 8-bit mod-256 sum of all data bytes as a trailer byte.
module img_uart_sender #(
   parameter int NUM_PIXELS      = 16384,
   parameter int ADDR_WIDTH      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1,
   parameter int PIXEL_WIDTH     = 8,
   parameter int BRAM_LATENCY    = 2,
   parameter int CLOCKS_PER_BAUD = 50
) (
   input  logic                   clk,
   input  logic                   rst_in,
   input  logic                   start_in,
   input  logic [PIXEL_WIDTH-1:0] data_in,
   output logic [ADDR_WIDTH-1:0]  addr_out,
   output logic                   busy_out,
   output logic                   done_out,
   output logic                   tx_out
);
   localparam int NUM_BYTES = PIXEL_WIDTH / 8;
   localparam int CNT_WIDTH = $clog2(CLOCKS_PER_BAUD);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = ADDR_WIDTH'(NUM_PIXELS - 1);
   localparam logic [CNT_WIDTH-1:0]  LAST_CNT      = CNT_WIDTH'(CLOCKS_PER_BAUD - 1);
   localparam logic [1:0]            LAST_BYTE     = 2'(NUM_BYTES - 1);
   localparam logic [2:0]            FETCH_WAIT    = 3'(BRAM_LATENCY);
   localparam logic [2:0]            PREFETCH_WAIT = 3'(BRAM_LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SHIFT = 2'd2
   } state_t;

   function automatic logic [7:0] pixel_byte(input logic [PIXEL_WIDTH-1:0] pixel, input logic [1:0] idx);
      logic [PIXEL_WIDTH-1:0] shifted;
      shifted = pixel >> {idx, 3'b000};
      return shifted[7:0];
   endfunction

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   tx_q, tx_d;
   logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;
   logic [7:0]             shreg_q, shreg_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [3:0]             bit_idx_q, bit_idx_d;
   logic [1:0]             byte_idx_q, byte_idx_d;
   logic [2:0]             fcnt_q, fcnt_d;
   logic                   last_pix_q, last_pix_d;
   logic                   load_s;
   logic                   data_load_s;
   logic [7:0]             load_byte_s;
`ifdef IMG_CHECKSUM_EN
   logic [7:0]             sum_q, sum_d;
   logic                   trailer_q, trailer_d;

   function automatic logic [7:0] checksum_add(input logic [7:0] sum, input logic [7:0] data);
      return sum + data;
   endfunction
`endif

   // Next-state, framing and prefetch logic
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      tx_d        = tx_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      byte_idx_d  = byte_idx_q;
      last_pix_d  = last_pix_q;
      load_s      = 1'b0;
      data_load_s = 1'b0;
      load_byte_s = 8'h00;
`ifdef IMG_CHECKSUM_EN
      sum_d       = sum_q;
      trailer_d   = trailer_q;
`endif
      if (fcnt_q != 3'd0) begin
         fcnt_d = fcnt_q - 3'd1;
      end else begin
         fcnt_d = 3'd0;
      end
      // fcnt reaching 1 marks the cycle in which data_in is valid for addr_q
      if (fcnt_q == 3'd1) begin
         pixel_d = data_in;
      end else begin
         pixel_d = pixel_q;
      end

      case (state_q)
         IDLE: begin
            if (start_in) begin
               state_d    = FETCH;
               busy_d     = 1'b1;
               addr_d     = {ADDR_WIDTH{1'b0}};
               fcnt_d     = FETCH_WAIT;
               last_pix_d = 1'b0;
`ifdef IMG_CHECKSUM_EN
               sum_d      = 8'h00;
               trailer_d  = 1'b0;
`endif
            end else begin
               tx_d = 1'b1;
            end
         end
         FETCH: begin
            if (fcnt_q == 3'd1) begin
               state_d     = SHIFT;
               byte_idx_d  = 2'd0;
               load_s      = 1'b1;
               load_byte_s = data_in[7:0];
            end else begin
               state_d = FETCH;
            end
         end
         SHIFT: begin
            if (cnt_q != LAST_CNT) begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end else if (bit_idx_q == 4'd8) begin
               cnt_d     = {CNT_WIDTH{1'b0}};
               bit_idx_d = 4'd9;
               tx_d      = 1'b1;
            end else if (bit_idx_q != 4'd9) begin
               cnt_d     = {CNT_WIDTH{1'b0}};
               bit_idx_d = bit_idx_q + 4'd1;
               tx_d      = shreg_q[0];
               shreg_d   = {1'b0, shreg_q[7:1]};
            end else if (byte_idx_q != LAST_BYTE) begin
               byte_idx_d  = byte_idx_q + 2'd1;
               load_s      = 1'b1;
               load_byte_s = pixel_byte(pixel_q, byte_idx_q + 2'd1);
            end else if (!last_pix_q) begin
               byte_idx_d  = 2'd0;
               load_s      = 1'b1;
               load_byte_s = pixel_byte(pixel_q, 2'd0);
`ifdef IMG_CHECKSUM_EN
            end else if (!trailer_q) begin
               trailer_d   = 1'b1;
               load_s      = 1'b1;
               load_byte_s = sum_q;
`endif
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               addr_d  = {ADDR_WIDTH{1'b0}};
               tx_d    = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            addr_d  = {ADDR_WIDTH{1'b0}};
            tx_d    = 1'b1;
         end
      endcase

`ifdef IMG_CHECKSUM_EN
      data_load_s = load_s && !trailer_d;
`else
      data_load_s = load_s;
`endif

      // Starting the last byte of a pixel is the moment to move the address on
      if (load_s) begin
         shreg_d   = load_byte_s;
         tx_d      = 1'b0;
         cnt_d     = {CNT_WIDTH{1'b0}};
         bit_idx_d = 4'd0;
         if (data_load_s && (byte_idx_d == LAST_BYTE)) begin
            if (addr_q != LAST_ADDR) begin
               addr_d = addr_q + ADDR_WIDTH'(1);
               fcnt_d = PREFETCH_WAIT;
            end else begin
               last_pix_d = 1'b1;
            end
         end else begin
            last_pix_d = last_pix_q;
         end
      end else begin
         shreg_d = shreg_d;
      end
`ifdef IMG_CHECKSUM_EN
      if (data_load_s) begin
         sum_d = checksum_add(sum_q, load_byte_s);
      end else begin
         sum_d = sum_d;
      end
`endif
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         addr_q     <= {ADDR_WIDTH{1'b0}};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tx_q       <= 1'b1;
         pixel_q    <= {PIXEL_WIDTH{1'b0}};
         shreg_q    <= 8'h00;
         cnt_q      <= {CNT_WIDTH{1'b0}};
         bit_idx_q  <= 4'd0;
         byte_idx_q <= 2'd0;
         fcnt_q     <= 3'd0;
         last_pix_q <= 1'b0;
`ifdef IMG_CHECKSUM_EN
         sum_q      <= 8'h00;
         trailer_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         tx_q       <= tx_d;
         pixel_q    <= pixel_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         fcnt_q     <= fcnt_d;
         last_pix_q <= last_pix_d;
`ifdef IMG_CHECKSUM_EN
         sum_q      <= sum_d;
         trailer_q  <= trailer_d;
`endif
      end
   end

   assign addr_out = addr_q;
   assign busy_out = busy_q;
   assign done_out = done_q;
   assign tx_out   = tx_q;

endmodule

// File: tb/tb_img_uart_sender.sv
// Directed bench for img_uart_sender: six parameterisations sharing one clock, each with its own BRAM model.
// Expected bytes and timings follow IMG_CHECKSUM_EN when it is defined for the build.
module tb_img_uart_sender;
   localparam int NINST = 6;

   logic             clk;
   logic             rst;
   logic [NINST-1:0] start_w;
   logic [NINST-1:0] tx_w;
   logic [NINST-1:0] busy_w;
   logic [NINST-1:0] done_w;
   logic [1:0]       addr_w [NINST];

   int n_checks;
   int n_fail;

   typedef struct {
      int          g;
      int          cpb;
      int          nbytes;
      logic [47:0] bytes;
      int          first;
      int          done_at;
      int          addr1;
      int          nchg;
   } vec_t;

   vec_t       vecs [6];
   logic       txh [512];
   logic       dh  [512];
   logic       bh  [512];
   logic [1:0] ah  [512];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // g0: 4x8-bit L2 CPB4, g1: 2x16-bit L2 CPB4, g2..g5: 4x8-bit CPB2 with latency 1..4
   for (genvar g = 0; g < NINST; g++) begin : g_dut
      localparam int NP  = (g == 1) ? 2 : 4;
      localparam int PW  = (g == 1) ? 16 : 8;
      localparam int LAT = (g < 2) ? 2 : g - 1;
      localparam int CPB = (g < 2) ? 4 : 2;
      localparam int AW  = $clog2(NP);

      logic [AW-1:0] addr_l;
      logic [15:0]   rd_l;
      logic [15:0]   pipe_q [4];
      logic [PW-1:0] data_l;

      if (g == 1) begin : g_mem16
         assign rd_l = (addr_l == AW'(0)) ? 16'hBEEF : 16'h1234;
      end else begin : g_mem8
         assign rd_l = 16'h0011 * (16'(addr_l) + 16'd1);
      end

      always_ff @(posedge clk) begin
         pipe_q[0] <= rd_l;
         for (int i = 1; i < 4; i++) pipe_q[i] <= pipe_q[i-1];
      end

      assign data_l    = pipe_q[LAT-1][PW-1:0];
      assign addr_w[g] = 2'(addr_l);

      img_uart_sender #(
         .NUM_PIXELS(NP),
         .PIXEL_WIDTH(PW),
         .BRAM_LATENCY(LAT),
         .CLOCKS_PER_BAUD(CPB)
      ) u_dut (
         .clk(clk),
         .rst_in(rst),
         .start_in(start_w[g]),
         .data_in(data_l),
         .addr_out(addr_l),
         .busy_out(busy_w[g]),
         .done_out(done_w[g]),
         .tx_out(tx_w[g])
      );
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic int exp_tx(input vec_t v, input int k);
      int off;
      int j;
      int b;
      if (k < v.first) return 1;
      off = k - v.first;
      j   = off / (10 * v.cpb);
      if (j >= v.nbytes) return 1;
      b = (off % (10 * v.cpb)) / v.cpb;
      if (b == 0) return 0;
      if (b == 9) return 1;
      return int'(v.bytes[8*j + b - 1]);
   endfunction

   task automatic sample(input int g, input int k);
      txh[k] = tx_w[g];
      dh[k]  = done_w[g];
      bh[k]  = busy_w[g];
      ah[k]  = addr_w[g];
   endtask

   task automatic run_frame(input vec_t v);
      int         n;
      int         errs;
      int         dcount;
      int         chg;
      int         base;
      logic [9:0] frame;
      logic [7:0] eb;
      n     = v.done_at + 4;
      ah[0] = addr_w[v.g];
      @(negedge clk);
      start_w[v.g] = 1'b1;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (k == 1) start_w[v.g] = 1'b0;
         sample(v.g, k);
      end
      chk($sformatf("g%0d_idle_before_start", v.g), int'(txh[v.first-1]), 1);
      chk($sformatf("g%0d_first_start_bit", v.g), int'(txh[v.first]), 0);
      for (int j = 0; j < v.nbytes; j++) begin
         base = v.first + j * 10 * v.cpb;
         for (int b = 0; b < 10; b++) frame[b] = txh[base + b * v.cpb + v.cpb / 2];
         eb = v.bytes[8*j +: 8];
         chk($sformatf("g%0d_byte%0d_frame", v.g, j), int'(frame), int'({1'b1, eb, 1'b0}));
      end
      errs   = 0;
      dcount = 0;
      chg    = 0;
      for (int k = 1; k <= n; k++) begin
         if (int'(txh[k]) != exp_tx(v, k)) errs++;
         if (dh[k]) dcount++;
         if (ah[k] != ah[k-1]) chg++;
      end
      chk($sformatf("g%0d_tx_wave_bad_cycles", v.g), errs, 0);
      chk($sformatf("g%0d_done_count", v.g), dcount, 1);
      chk($sformatf("g%0d_done_at", v.g), int'(dh[v.done_at]), 1);
      chk($sformatf("g%0d_busy_during", v.g), int'(bh[v.done_at-1]), 1);
      chk($sformatf("g%0d_busy_at_done", v.g), int'(bh[v.done_at]), 0);
      chk($sformatf("g%0d_addr_before_inc", v.g), int'(ah[v.addr1-1]), 0);
      chk($sformatf("g%0d_addr_first_inc", v.g), int'(ah[v.addr1]), 1);
      chk($sformatf("g%0d_addr_changes", v.g), chg, v.nchg);
      chk($sformatf("g%0d_addr_at_done", v.g), int'(ah[v.done_at]), 0);
   endtask

   initial begin
      int d;
      int dcount;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      start_w  = '0;
`ifdef IMG_CHECKSUM_EN
      vecs[0] = '{0, 4, 5, 48'h00_AA_44_33_22_11, 3, 203, 3, 4};
      vecs[1] = '{1, 4, 5, 48'h00_F3_12_34_BE_EF, 3, 203, 43, 2};
      vecs[2] = '{2, 2, 5, 48'h00_AA_44_33_22_11, 2, 102, 2, 4};
      vecs[3] = '{3, 2, 5, 48'h00_AA_44_33_22_11, 3, 103, 3, 4};
      vecs[4] = '{4, 2, 5, 48'h00_AA_44_33_22_11, 4, 104, 4, 4};
      vecs[5] = '{5, 2, 5, 48'h00_AA_44_33_22_11, 5, 105, 5, 4};
`else
      vecs[0] = '{0, 4, 4, 48'h00_00_44_33_22_11, 3, 163, 3, 4};
      vecs[1] = '{1, 4, 4, 48'h00_00_12_34_BE_EF, 3, 163, 43, 2};
      vecs[2] = '{2, 2, 4, 48'h00_00_44_33_22_11, 2, 82, 2, 4};
      vecs[3] = '{3, 2, 4, 48'h00_00_44_33_22_11, 3, 83, 3, 4};
      vecs[4] = '{4, 2, 4, 48'h00_00_44_33_22_11, 4, 84, 4, 4};
      vecs[5] = '{5, 2, 4, 48'h00_00_44_33_22_11, 5, 85, 5, 4};
`endif

      repeat (4) @(negedge clk);
      chk("reset_tx", int'(tx_w), 63);
      chk("reset_busy", int'(busy_w), 0);
      chk("reset_done", int'(done_w), 0);
      chk("reset_addr_g0", int'(addr_w[0]), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_tx", int'(tx_w), 63);
      chk("idle_busy", int'(busy_w), 0);

      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i]);
         repeat (3) @(negedge clk);
      end

      // start_in held high: one frame, then a second accepted in the done cycle
      d = vecs[0].done_at;
      @(negedge clk);
      start_w[0] = 1'b1;
      for (int k = 1; k <= 2 * d + 5; k++) begin
         @(negedge clk);
         if (k == d + 5) start_w[0] = 1'b0;
         sample(0, k);
      end
      dcount = 0;
      for (int k = 1; k <= 2 * d + 5; k++) if (dh[k]) dcount++;
      chk("hold_done_count", dcount, 2);
      chk("hold_first_done", int'(dh[d]), 1);
      chk("hold_second_done", int'(dh[2*d]), 1);
      chk("hold_busy_restart", int'(bh[d+1]), 1);
      chk("hold_idle_before_restart", int'(txh[d+2]), 1);
      chk("hold_restart_start_bit", int'(txh[d+3]), 0);
      chk("hold_idle_after", int'(bh[2*d+2]), 0);

      // reset during data bit 3 of byte 2 (0x33, bit value 0)
      @(negedge clk);
      start_w[0] = 1'b1;
      for (int k = 1; k <= 101; k++) begin
         @(negedge clk);
         if (k == 1) start_w[0] = 1'b0;
         sample(0, k);
      end
      chk("rst_pre_tx", int'(txh[101]), 0);
      chk("rst_pre_addr", int'(ah[101]), 3);
      chk("rst_pre_busy", int'(bh[101]), 1);
      rst = 1'b1;
      #1;
      chk("rst_async_tx", int'(tx_w[0]), 1);
      chk("rst_async_busy", int'(busy_w[0]), 0);
      chk("rst_async_addr", int'(addr_w[0]), 0);
      repeat (3) @(negedge clk);
      rst    = 1'b0;
      dcount = 0;
      for (int k = 0; k < 250; k++) begin
         @(negedge clk);
         if (done_w[0] || busy_w[0]) dcount++;
      end
      chk("rst_no_done_or_busy", dcount, 0);
      run_frame(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/img_uart_sender.md
# img_uart_sender

Parametrised image streamer that walks a frame buffer BRAM from address 0 to NUM_PIXELS-1 and serialises every pixel over an 8N1 UART line. Each pixel is sent least-significant byte first, and bytes go out back-to-back with no idle bits between them. It sits between the frame-buffer BRAM read port and the board UART TX pin, and replaces the fixed 16-pixel, 8-bit, single-byte sender. It adds configurable image size, pixel width, BRAM read latency, baud divider, a done pulse and an optional checksum trailer.

## Interface
- NUM_PIXELS, 16384: pixels per frame; must be at least 1.
- ADDR_WIDTH, $clog2(NUM_PIXELS): BRAM address width.
- PIXEL_WIDTH, 8: bits per pixel; a multiple of 8, from 8 to 32.
- BRAM_LATENCY, 2: cycles from an addr_out change to valid data_in; range 1 to 4.
- CLOCKS_PER_BAUD, 50: clk cycles per UART bit; must be at least 2.
- clk, input, 1: system clock.
- rst_in, input, 1: asynchronous, active-high reset.
- start_in, input, 1: level-sampled request to send one frame.
- data_in, input, PIXEL_WIDTH: BRAM read data.
- addr_out, output, ADDR_WIDTH: BRAM read address.
- busy_out, output, 1: high while a frame is in progress.
- done_out, output, 1: one-cycle pulse when a frame completes.
- tx_out, output, 1: UART serial output; idle level is high.

## Operation
- Reset values: addr_out=0, busy_out=0, done_out=0, tx_out=1, and the state machine is in IDLE. Reset takes effect immediately, including mid-byte.
- IDLE
  - If start_in=1, set busy_out=1, keep addr_out=0 and go to FETCH.
  - start_in is ignored whenever busy_out=1.
- FETCH
  - Wait BRAM_LATENCY cycles, then capture data_in into the pixel register.
  - Set the byte index to 0 and go to SHIFT.
- SHIFT
  - Each byte is framed as: start bit (0), then data bits 0 to 7 (LSB first), then stop bit (1). Each bit lasts CLOCKS_PER_BAUD cycles.
  - Byte k of a pixel is pixel[8k+7:8k].
  - In the first cycle of the last byte of a pixel, addr_out increments if more pixels remain.
  - The next pixel is prefetched and captured before that byte's stop bit ends. The next start bit therefore starts in the cycle immediately after the stop bit's last cycle.
- Completion
  - After the last byte of pixel NUM_PIXELS-1 (or after the checksum byte when IMG_CHECKSUM_EN is defined), return to IDLE.
  - In that cycle: busy_out=0, done_out=1, addr_out=0.
  - start_in is accepted in the same cycle done_out is high.
- addr_out never exceeds NUM_PIXELS-1. It wraps to 0 only at completion.
- The byte counter and address counter are sized so that NUM_PIXELS equal to 2^ADDR_WIDTH does not overflow early.

## Timing
- start_in is sampled high at cycle T.
  - The start bit of the first byte begins at cycle T+1+BRAM_LATENCY.
  - A frame lasts NUM_PIXELS × (PIXEL_WIDTH/8) × 10 × CLOCKS_PER_BAUD cycles of serial data, plus 10 × CLOCKS_PER_BAUD more when IMG_CHECKSUM_EN is defined.
  - done_out pulses in the first cycle after the final stop bit.
- Back-to-back bytes require 10 × CLOCKS_PER_BAUD > BRAM_LATENCY + 1. This holds for all legal parameter values.
- addr_out is registered and held stable from the cycle it changes until data_in has been captured.
- tx_out is driven directly from a flop, so there are no glitches.

## Configuration
- IMG_CHECKSUM_EN defined:
  - Keep an 8-bit running sum (mod 256) of every transmitted data byte, cleared on frame start.
  - After the last pixel, send the sum as one extra 8N1 byte. done_out follows that byte.
- IMG_CHECKSUM_EN undefined:
  - No accumulator and no trailer byte.
  - done_out follows the last pixel byte.

## Test plan
- NUM_PIXELS=4, PIXEL_WIDTH=8, BRAM_LATENCY=2, CLOCKS_PER_BAUD=4, BRAM contents 11,22,33,44 (hex), start_in pulsed at T:
  - tx_out decodes to 11, 22, 33, 44 with no idle cycles between bytes.
  - The start bit begins at T+3.
  - done_out pulses once at T+163 and busy_out falls in the same cycle.
- Same setup with IMG_CHECKSUM_EN defined:
  - A fifth byte AA follows 44.
  - done_out pulses at T+203.
- PIXEL_WIDTH=16, NUM_PIXELS=2, data BEEF then 1234:
  - Bytes arrive as EF, BE, 34, 12.
  - addr_out only ever takes the values 0 and 1, then returns to 0.
- start_in held high through an entire frame:
  - Exactly one frame is sent while busy.
  - A second frame begins in the done_out cycle.
- rst_in asserted during data bit 3 of byte 2:
  - tx_out=1, busy_out=0 and addr_out=0 immediately, without waiting for a clk edge.
  - No done_out pulse.
  - After rst_in is released, start_in sends a full frame from address 0.
- BRAM_LATENCY swept 1 to 4, CLOCKS_PER_BAUD=2:
  - Decoded bytes match memory.
  - Gap between bytes is 0 cycles.
  - First start bit at T+1+BRAM_LATENCY.
